// File: rtl/elm_layer_ctrl.sv
// Sequencer for one ELM hidden layer: streams weights/biases into the neuron array,
// broadcasts an input vector, collects activations and serializes them onto an output stream.
module elm_layer_ctrl #(
  parameter int unsigned LAYER_NO   = 1,
  parameter int unsigned NUM_NEURON = 64,
  parameter int unsigned NUM_INPUT  = 128,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_load,
  input  logic                         cmd_run,
  output logic                         busy,
  output logic                         err,
  input  logic [DATA_W-1:0]            s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [OUT_W-1:0]             m_data,
  output logic                         m_valid,
  output logic                         m_last,
  input  logic                         m_ready,
  output logic                         nrn_rst,
  output logic [2*DATA_W:0]            cfg_layer_num,
  output logic [2*DATA_W:0]            cfg_neuron_num,
  output logic                         weight_valid,
  output logic [DATA_W-1:0]            weight_value,
  output logic [NUM_NEURON-1:0]        bias_valid,
  output logic [DATA_W-1:0]            bias_value,
  output logic                         in_valid,
  output logic [DATA_W-1:0]            in_data,
  input  logic [NUM_NEURON*OUT_W-1:0]  n_out,
  input  logic [NUM_NEURON-1:0]        n_outvalid
);

  localparam int unsigned CW = 2 * DATA_W + 1;
  localparam int unsigned NW = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
  localparam int unsigned IW = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StNrst,
    StLoadW,
    StLoadB,
    StRunIn,
    StWaitOut,
    StDrain
  } state_e;

  state_e                      state_q, state_d;
  logic [NW-1:0]               n_q, n_d;
  logic [IW-1:0]               w_q, w_d;
  logic [TW-1:0]               timer_q, timer_d;
  logic [NW-1:0]               drain_q, drain_d;
  logic [NUM_NEURON-1:0]       seen_q, seen_d, seen_nxt;
  logic [NUM_NEURON*OUT_W-1:0] obuf_q, obuf_d;
  logic                        err_q, err_d;
  logic                        wvalid_q, wvalid_d;
  logic [DATA_W-1:0]           wvalue_q, wvalue_d;
  logic [CW-1:0]               cfg_nn_q, cfg_nn_d;
  logic [NUM_NEURON-1:0]       bvalid_q, bvalid_d;
  logic [DATA_W-1:0]           bvalue_q, bvalue_d;
  logic                        ivalid_q, ivalid_d;
  logic [DATA_W-1:0]           idata_q, idata_d;
  logic                        beat;
  logic [OUT_W-1:0]            obuf_arr [NUM_NEURON];

  for (genvar g = 0; g < NUM_NEURON; g++) begin : g_obuf
    assign obuf_arr[g] = obuf_q[g*OUT_W +: OUT_W];
  end

  // s_ready is a pure state decode so the upstream never sees a combinational loop
  assign s_ready = (state_q == StLoadW) || (state_q == StLoadB) || (state_q == StRunIn);
  assign beat    = s_valid & s_ready;

  assign busy           = (state_q != StIdle);
  assign err            = err_q;
  assign nrn_rst        = (state_q == StNrst);
  assign m_valid        = (state_q == StDrain);
  assign m_last         = m_valid && (drain_q == NW'(NUM_NEURON - 1));
  assign m_data         = m_valid ? obuf_arr[drain_q] : '0;
  assign cfg_layer_num  = CW'(LAYER_NO);
  assign cfg_neuron_num = cfg_nn_q;
  assign weight_valid   = wvalid_q;
  assign weight_value   = wvalue_q;
  assign bias_valid     = bvalid_q;
  assign bias_value     = bvalue_q;
  assign in_valid       = ivalid_q;
  assign in_data        = idata_q;

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    w_d      = w_q;
    timer_d  = timer_q;
    drain_d  = drain_q;
    seen_d   = seen_q;
    seen_nxt = seen_q;
    obuf_d   = obuf_q;
    err_d    = err_q;
    wvalid_d = 1'b0;
    wvalue_d = wvalue_q;
    cfg_nn_d = cfg_nn_q;
    bvalid_d = '0;
    bvalue_d = bvalue_q;
    ivalid_d = 1'b0;
    idata_d  = idata_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_load) begin
          err_d   = 1'b0;
          state_d = StNrst;
        end else if (cmd_run) begin
          err_d   = 1'b0;
          w_d     = '0;
          timer_d = '0;
          drain_d = '0;
          seen_d  = '0;
          state_d = StRunIn;
        end
      end

      StNrst: begin
        n_d     = '0;
        w_d     = '0;
        state_d = StLoadW;
      end

      StLoadW: begin
        if (beat) begin
          wvalid_d = 1'b1;
          wvalue_d = s_data;
          cfg_nn_d = CW'(n_q) + CW'(1);
          if (w_q == IW'(NUM_INPUT - 1)) begin
            w_d     = '0;
            state_d = StLoadB;
          end else begin
            w_d = w_q + IW'(1);
          end
        end
      end

      StLoadB: begin
        if (beat) begin
          bvalue_d = s_data;
          bvalid_d = NUM_NEURON'(1) << n_q;
          if (n_q == NW'(NUM_NEURON - 1)) begin
            state_d = StIdle;
          end else begin
            n_d     = n_q + NW'(1);
            w_d     = '0;
            state_d = StLoadW;
          end
        end
      end

      StRunIn: begin
        if (beat) begin
          ivalid_d = 1'b1;
          idata_d  = s_data;
          if (w_q == IW'(NUM_INPUT - 1)) begin
            w_d     = '0;
            timer_d = '0;
            state_d = StWaitOut;
          end else begin
            w_d = w_q + IW'(1);
          end
        end
      end

      StWaitOut: begin
        for (int k = 0; k < NUM_NEURON; k++) begin
          if (n_outvalid[k]) begin
            obuf_d[k*OUT_W +: OUT_W] = n_out[k*OUT_W +: OUT_W];
          end
        end
        seen_nxt = seen_q | n_outvalid;
        seen_d   = seen_nxt;
        // Activations arriving on the deadline cycle still count as complete
        if (&seen_nxt) begin
          drain_d = '0;
          state_d = StDrain;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      StDrain: begin
        if (m_ready) begin
          if (drain_q == NW'(NUM_NEURON - 1)) begin
            drain_d = '0;
            state_d = StIdle;
          end else begin
            drain_d = drain_q + NW'(1);
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      n_q      <= '0;
      w_q      <= '0;
      timer_q  <= '0;
      drain_q  <= '0;
      seen_q   <= '0;
      obuf_q   <= '0;
      err_q    <= 1'b0;
      wvalid_q <= 1'b0;
      wvalue_q <= '0;
      cfg_nn_q <= '0;
      bvalid_q <= '0;
      bvalue_q <= '0;
      ivalid_q <= 1'b0;
      idata_q  <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      w_q      <= w_d;
      timer_q  <= timer_d;
      drain_q  <= drain_d;
      seen_q   <= seen_d;
      obuf_q   <= obuf_d;
      err_q    <= err_d;
      wvalid_q <= wvalid_d;
      wvalue_q <= wvalue_d;
      cfg_nn_q <= cfg_nn_d;
      bvalid_q <= bvalid_d;
      bvalue_q <= bvalue_d;
      ivalid_q <= ivalid_d;
      idata_q  <= idata_d;
    end
  end

endmodule

// File: tb/tb_elm_layer_ctrl.sv
// Scoreboard bench for elm_layer_ctrl: directed stimulus pushes expectations, a monitor
// thread pops and compares every config strobe, input broadcast and output beat.
module tb_elm_layer_ctrl;

  localparam int unsigned NN = 2;
  localparam int unsigned NI = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned OW = 8;
  localparam int unsigned TO = 20;
  localparam int unsigned LN = 1;
  localparam int unsigned CW = 2 * DW + 1;

  logic              clk;
  logic              rst;
  logic              cmd_load;
  logic              cmd_run;
  logic              busy;
  logic              err;
  logic [DW-1:0]     s_data;
  logic              s_valid;
  logic              s_ready;
  logic [OW-1:0]     m_data;
  logic              m_valid;
  logic              m_last;
  logic              m_ready;
  logic              nrn_rst;
  logic [CW-1:0]     cfg_layer_num;
  logic [CW-1:0]     cfg_neuron_num;
  logic              weight_valid;
  logic [DW-1:0]     weight_value;
  logic [NN-1:0]     bias_valid;
  logic [DW-1:0]     bias_value;
  logic              in_valid;
  logic [DW-1:0]     in_data;
  logic [NN*OW-1:0]  n_out;
  logic [NN-1:0]     n_outvalid;

  elm_layer_ctrl #(
    .LAYER_NO   (LN),
    .NUM_NEURON (NN),
    .NUM_INPUT  (NI),
    .DATA_W     (DW),
    .OUT_W      (OW),
    .TIMEOUT    (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_load       (cmd_load),
    .cmd_run        (cmd_run),
    .busy           (busy),
    .err            (err),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_last         (m_last),
    .m_ready        (m_ready),
    .nrn_rst        (nrn_rst),
    .cfg_layer_num  (cfg_layer_num),
    .cfg_neuron_num (cfg_neuron_num),
    .weight_valid   (weight_valid),
    .weight_value   (weight_value),
    .bias_valid     (bias_valid),
    .bias_value     (bias_value),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .n_out          (n_out),
    .n_outvalid     (n_outvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [CW+DW-1:0] exp_w  [$];
  logic [NN+DW-1:0] exp_b  [$];
  logic [DW-1:0]    exp_in [$];
  logic [OW:0]      exp_m  [$];

  int          vectors;
  int          miscompares;
  int          nrst_pulses;
  logic        hold_pending;
  logic [OW+1:0] hold_val;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got unexpected %0h expected none", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pending = 1'b0;
      end else begin
        if (nrn_rst) nrst_pulses++;
        if (weight_valid) begin
          if (exp_w.size() == 0) unexpected("weight", {cfg_neuron_num, weight_value});
          else begin
            e = 64'(exp_w.pop_front());
            chk("weight", 64'({cfg_neuron_num, weight_value}), e);
          end
        end
        if (bias_valid != '0) begin
          if (exp_b.size() == 0) unexpected("bias", {bias_valid, bias_value});
          else begin
            e = 64'(exp_b.pop_front());
            chk("bias", 64'({bias_valid, bias_value}), e);
          end
        end
        if (in_valid) begin
          if (exp_in.size() == 0) unexpected("in_data", in_data);
          else begin
            e = 64'(exp_in.pop_front());
            chk("in_data", 64'(in_data), e);
          end
        end
        if (hold_pending) chk("m_hold", 64'({m_valid, m_last, m_data}), 64'(hold_val));
        hold_pending = 1'b0;
        if (m_valid && m_ready) begin
          if (exp_m.size() == 0) unexpected("m_beat", {m_last, m_data});
          else begin
            e = 64'(exp_m.pop_front());
            chk("m_beat", 64'({m_last, m_data}), e);
          end
        end else if (m_valid) begin
          hold_pending = 1'b1;
          hold_val     = {m_valid, m_last, m_data};
        end
      end
    end
  endtask

  task automatic do_load(input logic [DW-1:0] base);
    logic [DW-1:0] v;
    logic [NN-1:0] oh;
    int            p0;
    p0       = nrst_pulses;
    cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    chk("load_nrst", 64'(nrn_rst), 64'd1);
    chk("load_nrst_no_ready", 64'(s_ready), 64'd0);
    tick();
    chk("load_ready", 64'(s_ready), 64'd1);
    for (int n = 0; n < NN; n++) begin
      for (int w = 0; w < NI; w++) begin
        v = base + DW'(n * 16 + w);
        exp_w.push_back({CW'(n + 1), v});
        s_valid = 1'b1;
        s_data  = v;
        tick();
      end
      v  = base + DW'(16'h0100 + n);
      oh = NN'(1) << n;
      exp_b.push_back({oh, v});
      s_valid = 1'b1;
      s_data  = v;
      tick();
    end
    s_valid = 1'b0;
    chk("load_idle", 64'(busy), 64'd0);
    tick();
    chk("load_nrst_once", 64'(nrst_pulses - p0), 64'd1);
  endtask

  task automatic run_inputs(input bit gapped, input logic [DW-1:0] base);
    bit [5:0] pat;
    bit       v;
    int       got;
    pat = 6'b101101;
    got = 0;
    for (int i = 0; got < NI && i < 8; i++) begin
      v       = gapped ? pat[i] : 1'b1;
      s_valid = v;
      s_data  = base + DW'(i);
      if (v) begin
        exp_in.push_back(s_data);
        got++;
      end
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic start_run();
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    chk("run_ready", 64'(s_ready), 64'd1);
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (busy && c < 100) begin
      tick();
      c++;
    end
    chk(name, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int c;
    vectors      = 0;
    miscompares  = 0;
    nrst_pulses  = 0;
    hold_pending = 1'b0;
    hold_val     = '0;
    rst          = 1'b1;
    cmd_load     = 1'b0;
    cmd_run      = 1'b0;
    s_data       = '0;
    s_valid      = 1'b0;
    m_ready      = 1'b1;
    n_out        = '0;
    n_outvalid   = '0;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", 64'({busy, err, s_ready, m_valid, m_last, nrn_rst, weight_valid, in_valid}),
        64'd0);
    chk("rst_bias_valid", 64'(bias_valid), 64'd0);
    chk("rst_data", 64'({m_data, weight_value, bias_value, in_data}), 64'd0);
    chk("rst_cfg_nn", 64'(cfg_neuron_num), 64'd0);
    chk("rst_layer", 64'(cfg_layer_num), 64'(LN));
    rst = 1'b0;
    tick();

    // Full load, contiguous stream
    do_load(16'h1000);

    // Gapped run, neuron 1 answers first, neuron 0 three cycles later
    start_run();
    run_inputs(1'b1, 16'hC000);
    chk("run_wait_no_ready", 64'(s_ready), 64'd0);
    tick();
    exp_m.push_back({1'b0, 8'hA5});
    exp_m.push_back({1'b1, 8'h5A});
    n_out      = {8'h5A, 8'h33};
    n_outvalid = 2'b10;
    tick();
    n_outvalid = '0;
    n_out      = '0;
    tick();
    tick();
    n_out      = {8'h77, 8'hA5};
    n_outvalid = 2'b01;
    tick();
    n_outvalid = '0;
    n_out      = '0;
    wait_idle("drain1_idle");
    chk("drain1_no_valid", 64'(m_valid), 64'd0);

    // Output stall with m_ready 1,0,0,1
    m_ready = 1'b0;
    start_run();
    run_inputs(1'b0, 16'hD000);
    tick();
    exp_m.push_back({1'b0, 8'h11});
    exp_m.push_back({1'b1, 8'h22});
    n_out      = {8'h22, 8'h11};
    n_outvalid = 2'b11;
    tick();
    n_outvalid = '0;
    c = 0;
    while (!m_valid && c < 20) begin
      tick();
      c++;
    end
    chk("stall_drain_start", 64'(m_valid), 64'd1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    tick();
    tick();
    m_ready = 1'b1;
    tick();
    chk("stall_idle", 64'(busy), 64'd0);

    // Neuron 1 never answers
    start_run();
    run_inputs(1'b0, 16'hE000);
    n_out      = {8'h00, 8'h44};
    n_outvalid = 2'b01;
    c = 0;
    do begin
      tick();
      n_outvalid = '0;
      c++;
    end while (busy && c < 200);
    chk("timeout_cycles", 64'(c), 64'(TO));
    chk("timeout_err", 64'(err), 64'd1);
    chk("timeout_no_valid", 64'(m_valid), 64'd0);
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    chk("err_cleared", 64'(err), 64'd0);
    chk("err_clear_busy", 64'(busy), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_run_busy", 64'(busy), 64'd0);
    #3;
    rst = 1'b0;
    tick();

    // Asynchronous reset in the middle of LOAD_W
    cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) exp_w.push_back({CW'(1), DW'(16'hB000 + i)});
      s_valid = 1'b1;
      s_data  = DW'(16'hB000 + i);
      tick();
    end
    s_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ctrl", 64'({busy, s_ready, nrn_rst, weight_valid, in_valid, m_valid}), 64'd0);
    chk("mid_rst_cfg", 64'({cfg_neuron_num, weight_value}), 64'd0);
    #3;
    rst = 1'b0;
    tick();
    do_load(16'h2000);

    tick();
    chk("exp_w_empty", 64'(exp_w.size()), 64'd0);
    chk("exp_b_empty", 64'(exp_b.size()), 64'd0);
    chk("exp_in_empty", 64'(exp_in.size()), 64'd0);
    chk("exp_m_empty", 64'(exp_m.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/elm_layer_ctrl.md
# elm_layer_ctrl

Sequencer for one ELM hidden layer built from parallel neuron instances. It streams weights and per-neuron biases into the neurons over the shared config bus, then broadcasts an input vector to all neurons. It collects each neuron's activation and serializes the results onto an output stream. It sits between the AXI-stream front end and the neuron array of one layer.

## Interface
- LAYER_NO, 1: layer number driven on `cfg_layer_num`.
- NUM_NEURON, 64: neurons in the layer.
- NUM_INPUT, 128: inputs (weights) per neuron.
- DATA_W, 16: data/weight/bias width (`dataWidth`).
- OUT_W, 8: activation width per neuron (`ROM_bitwidth`).
- TIMEOUT, 1023: max cycles in WAIT_OUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset. Asynchronous, active-high.
- cmd_load  in  1  start a weight/bias load (IDLE only).
- cmd_run  in  1  start an inference (IDLE only; `cmd_load` wins if both are set).
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky timeout flag; cleared on the next accepted command.
- s_data  in  DATA_W  input stream data.
- s_valid  in  1  input stream valid.
- s_ready  out  1  input stream ready.
- m_data  out  OUT_W  output stream data (one neuron per beat).
- m_valid  out  1  output stream valid.
- m_last  out  1  high on the beat for neuron NUM_NEURON-1.
- m_ready  in  1  output stream ready.
- nrn_rst  out  1  synchronous reset pulse to all neurons.
- cfg_layer_num  out  2*DATA_W+1  constant LAYER_NO.
- cfg_neuron_num  out  2*DATA_W+1  target neuron index, 1-based.
- weight_valid  out  1  weight strobe.
- weight_value  out  DATA_W  weight data.
- bias_valid  out  NUM_NEURON  one-hot bias strobe.
- bias_value  out  DATA_W  bias data.
- in_valid  out  1  broadcast input strobe (`myinputValid`).
- in_data  out  DATA_W  broadcast input data.
- n_out  in  NUM_NEURON*OUT_W  neuron activations; neuron k occupies bits [k*OUT_W +: OUT_W].
- n_outvalid  in  NUM_NEURON  per-neuron outvalid.

## Operation
- States: IDLE, NRST, LOAD_W, LOAD_B, RUN_IN, WAIT_OUT, DRAIN.
- IDLE:
  - `cmd_load` -> NRST.
  - `cmd_run` -> RUN_IN.
  - Clear sticky flags and counters on entry to RUN_IN.
- NRST: assert `nrn_rst` for exactly 1 cycle, then go to LOAD_W with neuron index n=0 and word count w=0.
- LOAD_W: `s_ready`=1. On each beat (`s_valid&s_ready`):
  - register `weight_value`=`s_data`, `weight_valid`=1 next cycle, `cfg_neuron_num`=n+1;
  - w++; after w reaches NUM_INPUT-1 accepted, go to LOAD_B.
- LOAD_B: `s_ready`=1. On the beat, `bias_value`=`s_data` and `bias_valid`[n]=1 for 1 cycle.
  - If n==NUM_NEURON-1 -> IDLE.
  - Else n++, w=0 -> LOAD_W.
- Stream order in a load is therefore: neuron 0 weights 0..NUM_INPUT-1, bias0, neuron 1 weights, … Total NUM_NEURON*(NUM_INPUT+1) beats.
- RUN_IN: `s_ready`=1. Each beat gives `in_valid`=1 and `in_data`=`s_data` next cycle. Gaps in `s_valid` give `in_valid`=0. After NUM_INPUT beats -> WAIT_OUT.
- WAIT_OUT:
  - When `n_outvalid`[k]=1, capture `n_out` slice k into `buf`[k] and set `seen`[k].
  - When all `seen` bits are set -> DRAIN with index d=0.
  - If TIMEOUT cycles elapse first: set `err`, go to IDLE.
- DRAIN:
  - `m_valid`=1, `m_data`=`buf`[d], `m_last`=(d==NUM_NEURON-1).
  - On `m_ready`, d++. After the last beat -> IDLE.
- Commands outside IDLE are ignored.
- `n_outvalid` outside WAIT_OUT is ignored.
- Stream data arriving outside LOAD_W/LOAD_B/RUN_IN is held off (`s_ready`=0).

## Timing
- Reset values:
  - state IDLE; all counters 0; `buf` and `seen` 0;
  - `busy`, `err`, `s_ready`, `m_valid`, `m_last`, `nrn_rst`, `weight_valid`, `bias_valid`, `in_valid` = 0;
  - `m_data`, `weight_value`, `bias_value`, `in_data` = 0;
  - `cfg_neuron_num`=0; `cfg_layer_num`=LAYER_NO.
- A reset mid-operation aborts immediately; no partial output is emitted.
- `s_ready` is a decode of the state only. It is not a function of `s_valid`.
- Config strobes and data are registered: 1 cycle from the accepted beat.
  - `cfg_neuron_num` is valid in the same cycle as `weight_valid`.
  - `cfg_neuron_num` holds its value between strobes.
- `nrn_rst` precedes the first `weight_valid` by ≥1 cycle.
- Command to first `s_ready`:
  - load: 2 cycles (IDLE→NRST→LOAD_W);
  - run: 1 cycle.
- `m_data`/`m_valid`/`m_last` hold stable while `m_valid&!m_ready`.
- DRAIN with `m_ready`=1 constantly gives NUM_NEURON back-to-back beats.

## Test plan
- Load NUM_NEURON=2, NUM_INPUT=4 with a stream of 10 contiguous beats:
  - 8 `weight_valid` pulses; `cfg_neuron_num`=1,1,1,1,2,2,2,2;
  - `bias_valid`=01 then 10;
  - `nrn_rst` is a single pulse before the first weight;
  - then IDLE.
- Run with 4 inputs and `s_valid` gapped 1-0-1-1-0-1:
  - exactly 4 `in_valid` pulses with matching data.
- Neuron model returns outvalid for neuron 1 at cycle t and neuron 0 at t+3 with values 0x5A and 0xA5:
  - DRAIN emits 0xA5 then 0x5A, `m_last` on beat 2.
- `m_ready` toggling 1,0,0,1 during DRAIN:
  - data is held during the stall; no beat is lost or duplicated.
- Neuron 1 never asserts outvalid:
  - after TIMEOUT cycles, `err`=1, `busy`=0, no `m_valid`;
  - the next `cmd_run` clears `err`.
- Assert `rst` mid-LOAD_W (asynchronous, not clock-aligned):
  - all outputs take their reset values in that cycle; `cmd_load` afterwards restarts at neuron 1.
